ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_decoder.sv | 153 +++++++++++++++
 tb/tb_ps2_key_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// PS/2 keyboard receiver. It synchronises the raw PS/2 clock and data pins,
// frames 11-bit packets (start, 8 data LSB first, parity, stop), and follows
// the scan-code set 2 make / E0 / F0 sequence to present the key currently
// held as a level-valued code.
// Optional feature: define PS2_PARITY_CHECK_EN to drop frames with bad odd
// parity. Without it the parity bit is captured but ignored.
module ps2_key_decoder #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_dat,
   output logic [7:0] o_key,
   output logic       o_ext,
   output logic       o_key_valid,
   output logic [7:0] o_byte,
   output logic       o_byte_valid
);

   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   clk_prev;
   logic                   ps2_clk_s;
   logic                   ps2_dat_s;
   logic                   fe;

   state_t                 state;
   logic [2:0]             bit_cnt;
   logic [7:0]             shreg;
   logic                   par;
   logic [WD_W-1:0]        wd;
   logic                   ext;
   logic                   brk;
   logic                   parity_ok;
   logic                   frame_ok;

   assign ps2_clk_s = clk_sync[SYNC_STAGES-1];
   assign ps2_dat_s = dat_sync[SYNC_STAGES-1];
   assign fe        = clk_prev & ~ps2_clk_s;

`ifdef PS2_PARITY_CHECK_EN
   // Odd parity: data bits plus parity bit must contain an odd number of ones.
   assign parity_ok = ^{shreg, par};
`else
   logic unused_par;
   assign unused_par = par;
   assign parity_ok  = 1'b1;
`endif

   // In STOP the sampled data bit is the stop bit.
   assign frame_ok = ps2_dat_s & parity_ok;

   // Pin synchronisers; reset to the idle-high line level so release from
   // reset never looks like a falling edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
         clk_prev <= ps2_clk_s;
      end
   end

   // Frame FSM, watchdog and scan-code layer with registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         par          <= 1'b0;
         wd           <= '0;
         ext          <= 1'b0;
         brk          <= 1'b0;
         o_key        <= '0;
         o_ext        <= 1'b0;
         o_key_valid  <= 1'b0;
         o_byte       <= '0;
         o_byte_valid <= 1'b0;
      end else begin
         o_key_valid  <= 1'b0;
         o_byte_valid <= 1'b0;

         // Watchdog: cleared in IDLE and on every edge; on expiry mid-frame
         // the partial frame is abandoned. A coincident edge takes priority.
         if (state == IDLE || fe) begin
            wd <= '0;
         end else if (wd == WD_LAST) begin
            wd    <= '0;
            state <= IDLE;
         end else begin
            wd <= wd + 1'b1;
         end

         if (fe) begin
            case (state)
               IDLE: begin
                  if (!ps2_dat_s) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg   <= {ps2_dat_s, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par   <= ps2_dat_s;
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (frame_ok) begin
                     o_byte       <= shreg;
                     o_byte_valid <= 1'b1;
                     if (shreg == 8'hE0) begin
                        ext <= 1'b1;
                     end else if (shreg == 8'hF0) begin
                        brk <= 1'b1;
                     end else if (brk) begin
                        // Break only releases the most recently pressed key.
                        if (shreg == o_key && ext == o_ext) begin
                           o_key <= '0;
                           o_ext <= 1'b0;
                        end
                        ext <= 1'b0;
                        brk <= 1'b0;
                     end else begin
                        o_key       <= shreg;
                        o_ext       <= ext;
                        o_key_valid <= 1'b1;
                        ext         <= 1'b0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: directed PS/2 frames, scoreboard queue of
// expected per-frame results, and an independent monitor that pops and
// compares on every o_byte_valid pulse.
module tb_ps2_key_decoder;

   localparam int TMO  = 200;
   localparam int HALF = 10;

   typedef struct {
      logic [7:0] b;
      logic [7:0] key;
      logic       ext;
      logic       kv;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] key;
   logic       ext;
   logic       key_valid;
   logic [7:0] byte_out;
   logic       byte_valid;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   ps2_key_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_ps2_clk    (ps2_clk),
      .i_ps2_dat    (ps2_dat),
      .o_key        (key),
      .o_ext        (ext),
      .o_key_valid  (key_valid),
      .o_byte       (byte_out),
      .o_byte_valid (byte_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_bit(input logic v);
      ps2_dat = v;
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
   endtask

   // Full frame; expectation pushed only when the frame should be accepted.
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                             input logic push, input logic [7:0] ekey,
                             input logic eext, input logic ekv);
      exp_t e;
      if (push) begin
         e.b = b; e.key = ekey; e.ext = eext; e.kv = ekv;
         sb.push_back(e);
      end
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ bad_par);
      send_bit(stop);
      ps2_dat = 1'b1;
      wait_cyc(30);
   endtask

   task automatic good(input logic [7:0] b, input logic [7:0] ekey,
                       input logic eext, input logic ekv);
      send_frame(b, 1'b0, 1'b1, 1'b1, ekey, eext, ekv);
   endtask

   // Monitor: every output pulse must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && byte_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_byte", byte_out, 8'h00);
               vectors++; miscompares++;
               $display("FAIL unexpected_pulse: got byte %h expected none", byte_out);
            end else begin
               e = sb.pop_front();
               check("o_byte", byte_out, e.b);
               check("o_key", key, e.key);
               check("o_ext", {7'd0, ext}, {7'd0, e.ext});
               check("o_key_valid", {7'd0, key_valid}, {7'd0, e.kv});
            end
         end else if (rst_n && key_valid) begin
            vectors++; miscompares++;
            $display("FAIL stray_key_valid: got 1 expected 0 (no byte pulse)");
         end
      end
   end

   initial begin
      int guard;
      wait_cyc(4);
      check("rst_key", key, 8'h00);
      check("rst_ext", {7'd0, ext}, 8'h00);
      check("rst_byte", byte_out, 8'h00);
      check("rst_valids", {6'd0, key_valid, byte_valid}, 8'h00);
      rst_n = 1'b1;
      wait_cyc(10);

      // Make, then break of the same key.
      good(8'h5A, 8'h5A, 1'b0, 1'b1);
      good(8'hF0, 8'h5A, 1'b0, 1'b0);
      good(8'h5A, 8'h00, 1'b0, 1'b0);

      // Extended make; unrelated break ignored; extended break releases.
      good(8'hE0, 8'h00, 1'b0, 1'b0);
      good(8'h75, 8'h75, 1'b1, 1'b1);
      good(8'hF0, 8'h75, 1'b1, 1'b0);
      good(8'h72, 8'h75, 1'b1, 1'b0);
      good(8'hE0, 8'h75, 1'b1, 1'b0);
      good(8'hF0, 8'h75, 1'b1, 1'b0);
      good(8'h75, 8'h00, 1'b0, 1'b0);

      // Typematic repeat pulses key_valid each time.
      good(8'h1C, 8'h1C, 1'b0, 1'b1);
      good(8'h1C, 8'h1C, 1'b0, 1'b1);

      // Extended key, non-extended break of same code is ignored; F0 then E0.
      good(8'hE0, 8'h1C, 1'b0, 1'b0);
      good(8'h6B, 8'h6B, 1'b1, 1'b1);
      good(8'hF0, 8'h6B, 1'b1, 1'b0);
      good(8'h6B, 8'h6B, 1'b1, 1'b0);
      good(8'hF0, 8'h6B, 1'b1, 1'b0);
      good(8'hE0, 8'h6B, 1'b1, 1'b0);
      good(8'h6B, 8'h00, 1'b0, 1'b0);

      // Bad stop bit: always dropped.
      send_frame(8'h29, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("stop_err_key", key, 8'h00);

      // Flipped parity bit.
`ifdef PS2_PARITY_CHECK_EN
      send_frame(8'h76, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      check("par_err_key", key, 8'h00);
`else
      send_frame(8'h76, 1'b1, 1'b1, 1'b1, 8'h76, 1'b0, 1'b1);
      check("par_ign_key", key, 8'h76);
`endif

      // Partial frame then idle line: watchdog must resynchronise.
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      ps2_dat = 1'b1;
      wait_cyc(TMO + 50);
      good(8'h72, 8'h72, 1'b0, 1'b1);
      check("wd_key", key, 8'h72);

      // Reset mid-frame, during data bit 4.
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      ps2_dat = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_key", key, 8'h00);
      check("mid_rst_ext", {7'd0, ext}, 8'h00);
      check("mid_rst_byte", byte_out, 8'h00);
      check("mid_rst_valids", {6'd0, key_valid, byte_valid}, 8'h00);
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      wait_cyc(5);
      rst_n = 1'b1;
      wait_cyc(10);
      good(8'h5A, 8'h5A, 1'b0, 1'b1);
      check("post_rst_key", key, 8'h5A);

      // Every expected pulse must have been observed.
      guard = 0;
      while (sb.size() != 0 && guard < 100) begin
         wait_cyc(1);
         guard++;
      end
      check("sb_drained", 8'(sb.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
